// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI response codes, bus widths and FSM state encodings for the SRAM-backed AXI responder.
package axi_sram_slave_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 2;

    localparam logic [1:0]        AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]        AXI_RESP_SLVERR = 2'b10;
    localparam logic [DATA_W-1:0] ZERO_WORD       = '0;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_FETCH,
        RD_DATA
    } rd_state_e;

endpackage

// File: rtl/axi_sram_slave_sram.sv
// DEPTH x 32 SRAM: byte-enable write port, 1-cycle synchronous read port, read-first on collision.
// The read register only updates when re_i is high, so read data holds while the consumer stalls.
module sram_1r1w_be #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 responder over a word SRAM; independent write (AW/W/B) and read (AR/R) FSMs, INCR-by-4 bursts.
// Latency: AW hs N -> bvalid N+2 (single beat); AR hs N -> rvalid N+2, 2 cycles per further beat. Stalls hold outputs.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int unsigned       DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   axi_awid,
    input  logic [ADDR_W-1:0] axi_awaddr,
    input  logic [7:0]        axi_awlen,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [DATA_W-1:0] axi_wdata,
    input  logic [3:0]        axi_wstrb,
    input  logic              axi_wlast,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    output logic [ID_W-1:0]   axi_bid,
    output logic [1:0]        axi_bresp,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    input  logic [ID_W-1:0]   axi_arid,
    input  logic [ADDR_W-1:0] axi_araddr,
    input  logic [7:0]        axi_arlen,
    input  logic              axi_arvalid,
    output logic              axi_arready,
    output logic [ID_W-1:0]   axi_rid,
    output logic [DATA_W-1:0] axi_rdata,
    output logic [1:0]        axi_rresp,
    output logic              axi_rlast,
    output logic              axi_rvalid,
    input  logic              axi_rready
);

    localparam int unsigned       IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH) << 2;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    // Write beats are terminated by wlast alone.
    logic unused_awlen;
    assign unused_awlen = ^axi_awlen;

    wr_state_e         wr_q, wr_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              werr_q, werr_d;
    logic              sram_we;

    rd_state_e         rd_q, rd_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [7:0]        rcnt_q, rcnt_d;
    logic              rerr_q, rerr_d;
    logic              sram_re;
    logic [DATA_W-1:0] sram_rdata;

    assign axi_awready = (wr_q == WR_IDLE) && !rst;
    assign axi_wready  = (wr_q == WR_DATA) && !rst;
    assign axi_bvalid  = (wr_q == WR_RESP) && !rst;
    assign axi_bid     = bid_q;
    assign axi_bresp   = (axi_bvalid && werr_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

    assign axi_arready = (rd_q == RD_IDLE) && !rst;
    assign axi_rvalid  = (rd_q == RD_DATA) && !rst;
    assign axi_rid     = rid_q;
    assign axi_rdata   = (axi_rvalid && !rerr_q) ? sram_rdata : ZERO_WORD;
    assign axi_rresp   = (axi_rvalid && rerr_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign axi_rlast   = axi_rvalid && (rcnt_q == 8'd0);

    always_comb begin
        wr_d    = wr_q;
        bid_d   = bid_q;
        waddr_d = waddr_q;
        werr_d  = werr_q;
        sram_we = 1'b0;
        case (wr_q)
            WR_IDLE: if (axi_awvalid && axi_awready) begin
                bid_d   = axi_awid;
                waddr_d = axi_awaddr;
                werr_d  = 1'b0;
                wr_d    = WR_DATA;
            end
            WR_DATA: if (axi_wvalid && axi_wready) begin
                if (in_range(waddr_q)) sram_we = 1'b1;
                else                   werr_d  = 1'b1;
                waddr_d = waddr_q + 32'd4;
                if (axi_wlast) wr_d = WR_RESP;
            end
            WR_RESP: if (axi_bready) wr_d = WR_IDLE;
            default: wr_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_d    = rd_q;
        rid_d   = rid_q;
        raddr_d = raddr_q;
        rcnt_d  = rcnt_q;
        rerr_d  = rerr_q;
        sram_re = 1'b0;
        case (rd_q)
            RD_IDLE: if (axi_arvalid && axi_arready) begin
                rid_d   = axi_arid;
                raddr_d = axi_araddr;
                rcnt_d  = axi_arlen;
                rd_d    = RD_FETCH;
            end
            RD_FETCH: begin
                sram_re = !rst;
                rerr_d  = !in_range(raddr_q);
                rd_d    = RD_DATA;
            end
            RD_DATA: if (axi_rready) begin
                if (rcnt_q == 8'd0) begin
                    rd_d = RD_IDLE;
                end else begin
                    rcnt_d  = rcnt_q - 8'd1;
                    raddr_d = raddr_q + 32'd4;
                    rd_d    = RD_FETCH;
                end
            end
            default: rd_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= WR_IDLE;
            bid_q   <= '0;
            waddr_q <= '0;
            werr_q  <= 1'b0;
            rd_q    <= RD_IDLE;
            rid_q   <= '0;
            raddr_q <= '0;
            rcnt_q  <= '0;
            rerr_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            bid_q   <= bid_d;
            waddr_q <= waddr_d;
            werr_q  <= werr_d;
            rd_q    <= rd_d;
            rid_q   <= rid_d;
            raddr_q <= raddr_d;
            rcnt_q  <= rcnt_d;
            rerr_q  <= rerr_d;
        end
    end

    sram_1r1w_be #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_sram (
        .clk     (clk),
        .we_i    (sram_we && !rst),
        .be_i    (axi_wstrb),
        .waddr_i (word_idx(waddr_q)),
        .wdata_i (axi_wdata),
        .re_i    (sram_re),
        .raddr_i (word_idx(raddr_q)),
        .rdata_o (sram_rdata)
    );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench: stimulus pushes expected B/R responses into queues, a negedge monitor pops and compares them.
module tb_axi_sram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  axi_awid;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic        axi_awvalid, axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast, axi_wvalid, axi_wready;
    logic [1:0]  axi_bid, axi_bresp;
    logic        axi_bvalid, axi_bready;
    logic [1:0]  axi_arid;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic        axi_arvalid, axi_arready;
    logic [1:0]  axi_rid;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast, axi_rvalid, axi_rready;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    b_exp_t      exp_b[$];
    r_exp_t      exp_r[$];
    logic [31:0] wbuf [8];
    int          n_total = 0;
    int          n_pass  = 0;
    logic        rr_toggle = 1'b0;

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    axi_sram_slave #(.DEPTH(1024), .BASE_ADDR(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .axi_awid    (axi_awid),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wlast   (axi_wlast),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bid     (axi_bid),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_arid    (axi_arid),
        .axi_araddr  (axi_araddr),
        .axi_arlen   (axi_arlen),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rid     (axi_rid),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rlast   (axi_rlast),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pops expectations on every B/R handshake and checks R stays frozen while stalled.
    logic        r_stall_prev = 1'b0;
    logic [36:0] r_saved;
    initial begin
        forever begin
            @(negedge clk);
            if (axi_bvalid && axi_bready) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected", 64'(exp_b.size()), 64'd1);
                end else begin
                    b_exp_t e;
                    e = exp_b.pop_front();
                    check("b_id", 64'(axi_bid), 64'(e.id));
                    check("b_resp", 64'(axi_bresp), 64'(e.resp));
                end
            end
            if (axi_rvalid) begin
                if (r_stall_prev)
                    check("r_hold", 64'({axi_rid, axi_rdata, axi_rresp, axi_rlast}), 64'(r_saved));
                if (axi_rready) begin
                    if (exp_r.size() == 0) begin
                        check("r_unexpected", 64'(exp_r.size()), 64'd1);
                    end else begin
                        r_exp_t e;
                        e = exp_r.pop_front();
                        check("r_id", 64'(axi_rid), 64'(e.id));
                        check("r_data", 64'(axi_rdata), 64'(e.data));
                        check("r_resp", 64'(axi_rresp), 64'(e.resp));
                        check("r_last", 64'(axi_rlast), 64'(e.last));
                    end
                    r_stall_prev = 1'b0;
                end else begin
                    r_stall_prev = 1'b1;
                    r_saved = {axi_rid, axi_rdata, axi_rresp, axi_rlast};
                end
            end else begin
                r_stall_prev = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_toggle) axi_rready = ~axi_rready;
        end
    end

    task automatic do_write(input logic [1:0] id, input logic [31:0] addr, input logic [3:0] s,
                            input int n, input logic [1:0] resp);
        int   beat;
        int   t;
        logic aw_hs, w_hs;
        exp_b.push_back({id, resp});
        beat = 0;
        t    = 0;
        axi_awid = id; axi_awaddr = addr; axi_awlen = 8'(n - 1); axi_awvalid = 1'b1;
        axi_wdata = wbuf[0]; axi_wstrb = s; axi_wlast = (n == 1); axi_wvalid = 1'b1;
        while ((axi_awvalid || axi_wvalid) && t < 100) begin
            @(negedge clk);
            aw_hs = axi_awvalid && axi_awready;
            w_hs  = axi_wvalid && axi_wready;
            @(posedge clk);
            #1;
            t++;
            if (aw_hs) axi_awvalid = 1'b0;
            if (w_hs) begin
                beat++;
                if (beat == n) begin
                    axi_wvalid = 1'b0;
                    axi_wlast  = 1'b0;
                end else begin
                    axi_wdata = wbuf[beat];
                    axi_wlast = (beat == n - 1);
                end
            end
        end
        check("wr_timeout", 64'(t < 100), 64'd1);
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
    endtask

    task automatic issue_ar(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len);
        int   t;
        logic hs;
        t  = 0;
        hs = 1'b0;
        axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arvalid = 1'b1;
        while (!hs && t < 100) begin
            @(negedge clk);
            hs = axi_arready;
            @(posedge clk);
            #1;
            t++;
        end
        check("ar_timeout", 64'(hs), 64'd1);
        axi_arvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_b", 64'(exp_b.size()), 64'd0);
        check("drain_r", 64'(exp_r.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic read_one(input logic [1:0] id, input logic [31:0] addr,
                            input logic [31:0] data, input logic [1:0] resp);
        exp_r.push_back({id, data, resp, 1'b1});
        issue_ar(id, addr, 8'd0);
        wait_drain();
    endtask

    initial begin
        rst = 1'b1;
        axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awvalid = 1'b0;
        axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
        axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arvalid = 1'b0;
        axi_bready = 1'b1; axi_rready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 64'(axi_awready), 64'd0);
        check("rst_wready", 64'(axi_wready), 64'd0);
        check("rst_arready", 64'(axi_arready), 64'd0);
        check("rst_bvalid", 64'(axi_bvalid), 64'd0);
        check("rst_rvalid", 64'(axi_rvalid), 64'd0);
        check("rst_bresp_bid", 64'({axi_bresp, axi_bid}), 64'd0);
        check("rst_r_fields", 64'({axi_rresp, axi_rid, axi_rlast}), 64'd0);
        check("rst_rdata", 64'(axi_rdata), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: single write with AW+W together, bvalid two cycles after AW hs
        axi_awid = 2'd1; axi_awaddr = 32'h10; axi_awlen = 8'd0; axi_awvalid = 1'b1;
        axi_wdata = 32'hDEAD_BEEF; axi_wstrb = 4'hF; axi_wlast = 1'b1; axi_wvalid = 1'b1;
        exp_b.push_back({2'd1, OK});
        @(negedge clk);
        check("t1_awready", 64'(axi_awready), 64'd1);
        @(posedge clk);
        #1 axi_awvalid = 1'b0;
        @(negedge clk);
        check("t1_wready", 64'(axi_wready), 64'd1);
        check("t1_bvalid_early", 64'(axi_bvalid), 64'd0);
        @(posedge clk);
        #1 axi_wvalid = 1'b0; axi_wlast = 1'b0;
        @(negedge clk);
        check("t1_bvalid_n2", 64'(axi_bvalid), 64'd1);
        wait_drain();
        exp_r.push_back({2'd2, 32'hDEAD_BEEF, OK, 1'b1});
        issue_ar(2'd2, 32'h10, 8'd0);
        @(negedge clk);
        check("t1_rvalid_n1", 64'(axi_rvalid), 64'd0);
        @(negedge clk);
        check("t1_rvalid_n2", 64'(axi_rvalid), 64'd1);
        wait_drain();

        // 2: partial-strobe overwrite
        wbuf[0] = 32'h1122_3344;
        do_write(2'd0, 32'h20, 4'hF, 1, OK);
        wbuf[0] = 32'hAABB_CCDD;
        do_write(2'd3, 32'h20, 4'b0101, 1, OK);
        wait_drain();
        read_one(2'd1, 32'h20, 32'h11BB_33DD, OK);

        // 3: 4-beat write then 4-beat read with rready toggling
        wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
        do_write(2'd2, 32'h40, 4'hF, 4, OK);
        wait_drain();
        for (int i = 0; i < 4; i++)
            exp_r.push_back({2'd3, 32'(i + 1), OK, (i == 3)});
        rr_toggle = 1'b1;
        issue_ar(2'd3, 32'h40, 8'd3);
        wait_drain();
        rr_toggle = 1'b0;
        axi_rready = 1'b1;

        // 4: out-of-range accesses and a burst straddling the top word
        wbuf[0] = 32'h0A0A_0A0A;
        do_write(2'd0, 32'h0, 4'hF, 1, OK);
        wbuf[0] = 32'hCAFE_BABE;
        do_write(2'd1, 32'h1000, 4'hF, 1, ERR);
        wait_drain();
        read_one(2'd0, 32'h0, 32'h0A0A_0A0A, OK);
        read_one(2'd2, 32'h1000, 32'h0, ERR);
        wbuf[0] = 32'h1234_5678; wbuf[1] = 32'h9ABC_DEF0;
        do_write(2'd2, 32'hFFC, 4'hF, 2, ERR);
        wait_drain();
        exp_r.push_back({2'd1, 32'h1234_5678, OK, 1'b0});
        exp_r.push_back({2'd1, 32'h0, ERR, 1'b1});
        issue_ar(2'd1, 32'hFFC, 8'd1);
        wait_drain();
        read_one(2'd0, 32'h0, 32'h0A0A_0A0A, OK);

        // 5: W ahead of AW, then B held under bready=0
        axi_bready = 1'b0;
        axi_wdata = 32'h55AA_55AA; axi_wstrb = 4'hF; axi_wlast = 1'b1; axi_wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_wready_early", 64'(axi_wready), 64'd0);
            @(posedge clk);
            #1;
        end
        exp_b.push_back({2'd3, OK});
        axi_awid = 2'd3; axi_awaddr = 32'h100; axi_awlen = 8'd0; axi_awvalid = 1'b1;
        @(negedge clk);
        check("t5_wready_at_aw", 64'(axi_wready), 64'd0);
        @(posedge clk);
        #1 axi_awvalid = 1'b0;
        @(negedge clk);
        check("t5_wready_after_aw", 64'(axi_wready), 64'd1);
        @(posedge clk);
        #1 axi_wvalid = 1'b0; axi_wlast = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_b", 64'({axi_bvalid, axi_bresp, axi_bid}), 64'({1'b1, OK, 2'd3}));
        end
        @(posedge clk);
        #1 axi_bready = 1'b1;
        wait_drain();
        read_one(2'd2, 32'h100, 32'h55AA_55AA, OK);

        // 6: same-cycle read and write of one word returns old data
        wbuf[0] = 32'h5;
        do_write(2'd0, 32'h80, 4'hF, 1, OK);
        wait_drain();
        exp_b.push_back({2'd2, OK});
        exp_r.push_back({2'd1, 32'h5, OK, 1'b1});
        axi_awid = 2'd2; axi_awaddr = 32'h80; axi_awlen = 8'd0; axi_awvalid = 1'b1;
        axi_wdata = 32'h77; axi_wstrb = 4'hF; axi_wlast = 1'b1; axi_wvalid = 1'b1;
        axi_arid = 2'd1; axi_araddr = 32'h80; axi_arlen = 8'd0; axi_arvalid = 1'b1;
        @(negedge clk);
        check("t6_aw_ar_ready", 64'({axi_awready, axi_arready}), 64'd3);
        @(posedge clk);
        #1 axi_awvalid = 1'b0; axi_arvalid = 1'b0;
        @(negedge clk);
        check("t6_wready", 64'(axi_wready), 64'd1);
        @(posedge clk);
        #1 axi_wvalid = 1'b0; axi_wlast = 1'b0;
        wait_drain();
        read_one(2'd3, 32'h80, 32'h77, OK);

        // reset in the middle of a stalled read burst
        axi_rready = 1'b0;
        issue_ar(2'd2, 32'h40, 8'd3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("rst_mid_rvalid_before", 64'(axi_rvalid), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_rvalid", 64'(axi_rvalid), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_arready", 64'(axi_arready), 64'd1);
        @(posedge clk);
        #1 axi_rready = 1'b1;
        read_one(2'd1, 32'h44, 32'd2, OK);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
